// File: rtl/mem_port_arbiter_pkg.sv
// Purpose : shared encodings for the fetch/data memory port arbiter.
// Latency : n/a (constants and types only).
// Backpr. : n/a.
package mem_port_arbiter_pkg;

    // Source tag recorded per issued request, consumed when its response returns.
    localparam logic TAG_INST = 1'b0;
    localparam logic TAG_DATA = 1'b1;

    // Size driven downstream for instruction fetches (word access).
    localparam logic [2:0] INST_SIZE = 3'd2;

    // Grant state: IDLE arbitrates freely, LOCK_x holds a presented but
    // not-yet-accepted request from source x so the bus stays stable.
    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        LOCK_I = 2'd1,
        LOCK_D = 2'd2
    } grant_state_t;

endpackage

// File: rtl/mem_port_arbiter_tag_fifo.sv
// Purpose : 1-bit in-order source-tag ring buffer, DEPTH entries (power of 2).
// Latency : push visible at dout/count the cycle after; dout is the head, read combinationally.
// Backpr. : push ignored when full, pop ignored when empty; caller gates both.
// Ports   : clk/resetn, push/din in, pop in, dout/full/empty/count out.
module tag_fifo
    import mem_port_arbiter_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     resetn,
    input  logic                     push,
    input  logic                     pop,
    input  logic                     din,
    output logic                     dout,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic [DEPTH-1:0] mem;
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic             push_ok;
    logic             pop_ok;

    assign full    = (count == CNT_W'(DEPTH));
    assign empty   = (count == '0);
    assign push_ok = push && !full;
    assign pop_ok  = pop && !empty;
    assign dout    = mem[rd_ptr];

    // Tag storage needs no reset: an entry is only read after it was written.
    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem[wr_ptr] <= din;
        end
    end

    // Pointers wrap naturally because DEPTH is a power of 2.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push_ok) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop_ok) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({push_ok, pop_ok})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/mem_port_arbiter.sv
// Purpose : merges fetch and data split-transaction ports onto one memory port; data has priority.
// Latency : zero-cycle combinational request mux, addr_ok and data_ok pass-through.
// Backpr. : bus_req held off while MAX_OUTST requests are outstanding; a pending grant is locked until accepted.
// Ports   : inst_* fetch port, data_* data port, bus_* downstream port,
//           outst_cnt outstanding request count, err sticky protocol error.
module mem_port_arbiter
    import mem_port_arbiter_pkg::*;
#(
    parameter int MAX_OUTST = 4,
    parameter int CNT_W     = $clog2(MAX_OUTST) + 1
) (
    input  logic             clk,
    input  logic             resetn,
    input  logic             inst_req,
    input  logic             inst_cache,
    input  logic [31:0]      inst_addr,
    output logic             inst_addr_ok,
    output logic             inst_data_ok,
    output logic [31:0]      inst_rdata,
    input  logic             data_req,
    input  logic             data_cache,
    input  logic             data_wr,
    input  logic [3:0]       data_wstrb,
    input  logic [2:0]       data_size,
    input  logic [31:0]      data_addr,
    input  logic [31:0]      data_wdata,
    output logic             data_addr_ok,
    output logic             data_data_ok,
    output logic [31:0]      data_rdata,
    output logic             bus_req,
    output logic             bus_cache,
    output logic             bus_wr,
    output logic [3:0]       bus_wstrb,
    output logic [2:0]       bus_size,
    output logic [31:0]      bus_addr,
    output logic [31:0]      bus_wdata,
    input  logic             bus_addr_ok,
    input  logic             bus_data_ok,
    input  logic [31:0]      bus_rdata,
    output logic [CNT_W-1:0] outst_cnt,
    output logic             err
);

    grant_state_t state;
    grant_state_t state_nxt;
    logic         grant_i;
    logic         grant_d;
    logic         lock_drop;
    logic         issue;
    logic         pop;
    logic         fifo_full;
    logic         fifo_empty;
    logic         head_tag;

    tag_fifo #(
        .DEPTH (MAX_OUTST)
    ) u_tag_fifo (
        .clk    (clk),
        .resetn (resetn),
        .push   (issue),
        .pop    (pop),
        .din    (grant_d ? TAG_DATA : TAG_INST),
        .dout   (head_tag),
        .full   (fifo_full),
        .empty  (fifo_empty),
        .count  (outst_cnt)
    );

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Grants already include the source's req, so bus_req is just "any grant".
    // The full check only matters in IDLE: a lock is entered while not full and
    // only pops can happen before it is released, so it never becomes full.
    always_comb begin
        state_nxt = state;
        grant_i   = 1'b0;
        grant_d   = 1'b0;
        lock_drop = 1'b0;
        case (state)
            IDLE: begin
                if (!fifo_full) begin
                    if (data_req) begin
                        grant_d = 1'b1;
                    end else if (inst_req) begin
                        grant_i = 1'b1;
                    end
                end
            end
            LOCK_I: begin
                if (inst_req) begin
                    grant_i = 1'b1;
                end else begin
                    lock_drop = 1'b1;
                    state_nxt = IDLE;
                end
            end
            LOCK_D: begin
                if (data_req) begin
                    grant_d = 1'b1;
                end else begin
                    lock_drop = 1'b1;
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
        if (grant_i || grant_d) begin
            if (bus_addr_ok) begin
                state_nxt = IDLE;
            end else begin
                state_nxt = grant_d ? LOCK_D : LOCK_I;
            end
        end
    end

    assign bus_req = grant_i || grant_d;
    assign issue   = bus_req && bus_addr_ok;

    always_comb begin
        bus_cache = 1'b0;
        bus_wr    = 1'b0;
        bus_wstrb = 4'd0;
        bus_size  = 3'd0;
        bus_addr  = 32'd0;
        bus_wdata = 32'd0;
        if (grant_d) begin
            bus_cache = data_cache;
            bus_wr    = data_wr;
            bus_wstrb = data_wstrb;
            bus_size  = data_size;
            bus_addr  = data_addr;
            bus_wdata = data_wdata;
        end else if (grant_i) begin
            bus_cache = inst_cache;
            bus_size  = INST_SIZE;
            bus_addr  = inst_addr;
        end
    end

    assign inst_addr_ok = bus_addr_ok && grant_i && bus_req;
    assign data_addr_ok = bus_addr_ok && grant_d && bus_req;

    // Responses return in issue order, so the FIFO head names the owner.
    assign pop          = bus_data_ok && !fifo_empty;
    assign inst_data_ok = pop && (head_tag == TAG_INST);
    assign data_data_ok = pop && (head_tag == TAG_DATA);
    assign inst_rdata   = bus_rdata;
    assign data_rdata   = bus_rdata;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            err <= 1'b0;
        end else if (lock_drop || (bus_data_ok && fifo_empty)) begin
            err <= 1'b1;
        end
    end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Purpose : self-checking bench for mem_port_arbiter against a queue-based model.
// Latency : model predicts combinational outputs each cycle and the registered count/err.
// Backpr. : bench masters hold a request until its addr_ok, as a real core would.
module tb_mem_port_arbiter;

    localparam int MAX   = 4;
    localparam int CNT_W = 3;

    logic             clk = 1'b0;
    logic             resetn;
    logic             inst_req, inst_cache;
    logic [31:0]      inst_addr;
    logic             inst_addr_ok, inst_data_ok;
    logic [31:0]      inst_rdata;
    logic             data_req, data_cache, data_wr;
    logic [3:0]       data_wstrb;
    logic [2:0]       data_size;
    logic [31:0]      data_addr, data_wdata;
    logic             data_addr_ok, data_data_ok;
    logic [31:0]      data_rdata;
    logic             bus_req, bus_cache, bus_wr;
    logic [3:0]       bus_wstrb;
    logic [2:0]       bus_size;
    logic [31:0]      bus_addr, bus_wdata;
    logic             bus_addr_ok, bus_data_ok;
    logic [31:0]      bus_rdata;
    logic [CNT_W-1:0] outst_cnt;
    logic             err;

    always #5 clk = ~clk;

    mem_port_arbiter #(.MAX_OUTST(MAX)) dut (
        .clk(clk), .resetn(resetn),
        .inst_req(inst_req), .inst_cache(inst_cache), .inst_addr(inst_addr),
        .inst_addr_ok(inst_addr_ok), .inst_data_ok(inst_data_ok), .inst_rdata(inst_rdata),
        .data_req(data_req), .data_cache(data_cache), .data_wr(data_wr),
        .data_wstrb(data_wstrb), .data_size(data_size), .data_addr(data_addr),
        .data_wdata(data_wdata), .data_addr_ok(data_addr_ok), .data_data_ok(data_data_ok),
        .data_rdata(data_rdata),
        .bus_req(bus_req), .bus_cache(bus_cache), .bus_wr(bus_wr), .bus_wstrb(bus_wstrb),
        .bus_size(bus_size), .bus_addr(bus_addr), .bus_wdata(bus_wdata),
        .bus_addr_ok(bus_addr_ok), .bus_data_ok(bus_data_ok), .bus_rdata(bus_rdata),
        .outst_cnt(outst_cnt), .err(err)
    );

    int n_cmp = 0;
    int n_mis = 0;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_mis++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Reference model: queue of outstanding sources (0=inst, 1=data),
    // the source whose presented request is still waiting (-1 none), sticky err.
    int q[$];
    int pend     = -1;
    bit exp_err  = 1'b0;
    bit inst_busy = 1'b0;
    bit data_busy = 1'b0;
    int n_full_seen = 0;

    task automatic eval_cycle();
        int  g;
        bit  drop;
        logic [63:0] exp_fields;
        drop = 1'b0;
        if (pend >= 0) begin
            if ((pend == 0 && !inst_req) || (pend == 1 && !data_req)) begin
                g = -1;
                drop = 1'b1;
            end else begin
                g = pend;
            end
        end else if (q.size() >= MAX) begin
            g = -1;
            n_full_seen++;
        end else if (data_req) begin
            g = 1;
        end else if (inst_req) begin
            g = 0;
        end else begin
            g = -1;
        end

        if (g == 1)
            exp_fields = {data_cache, data_wr, data_wstrb, data_size, data_wdata};
        else if (g == 0)
            exp_fields = {inst_cache, 1'b0, 4'd0, 3'd2, 32'd0};
        else
            exp_fields = '0;

        check_eq("bus_req", bus_req, g >= 0);
        check_eq("bus_addr", bus_addr, g == 1 ? data_addr : (g == 0 ? inst_addr : 32'd0));
        check_eq("bus_fields", {bus_cache, bus_wr, bus_wstrb, bus_size, bus_wdata}, exp_fields);
        check_eq("addr_ok", {inst_addr_ok, data_addr_ok},
                 {bus_addr_ok && g == 0, bus_addr_ok && g == 1});
        check_eq("data_ok", {inst_data_ok, data_data_ok},
                 {bus_data_ok && q.size() > 0 && q[0] == 0,
                  bus_data_ok && q.size() > 0 && q[0] == 1});
        check_eq("rdata", {inst_rdata, data_rdata}, {bus_rdata, bus_rdata});
        check_eq("outst_cnt", outst_cnt, q.size());
        check_eq("err", err, exp_err);

        if (bus_data_ok) begin
            if (q.size() > 0) void'(q.pop_front());
            else exp_err = 1'b1;
        end
        if (drop) exp_err = 1'b1;
        if (g >= 0 && bus_addr_ok) q.push_back(g);
        pend = (g >= 0 && !bus_addr_ok) ? g : -1;
        inst_busy = inst_req && !(g == 0 && bus_addr_ok);
        data_busy = data_req && !(g == 1 && bus_addr_ok);
    endtask

    task automatic drive_rand(input int dok_pct, input int aok_pct, input bit allow);
        if (!inst_busy) begin
            inst_req   = allow && ($urandom_range(99) < 55);
            inst_addr  = $urandom;
            inst_cache = 1'($urandom_range(1));
        end
        if (!data_busy) begin
            data_req   = allow && ($urandom_range(99) < 45);
            data_cache = 1'($urandom_range(1));
            data_wr    = 1'($urandom_range(1));
            data_wstrb = 4'($urandom_range(15));
            data_size  = 3'($urandom_range(7));
            data_addr  = $urandom;
            data_wdata = $urandom;
        end
        bus_addr_ok = $urandom_range(99) < aok_pct;
        bus_data_ok = (q.size() > 0) && ($urandom_range(99) < dok_pct);
        bus_rdata   = $urandom;
    endtask

    task automatic step(input int dok_pct, input int aok_pct, input bit allow);
        @(posedge clk); #1;
        drive_rand(dok_pct, aok_pct, allow);
        @(negedge clk);
        eval_cycle();
    endtask

    task automatic idle_inputs();
        inst_req = 0; inst_cache = 0; inst_addr = 0;
        data_req = 0; data_cache = 0; data_wr = 0; data_wstrb = 0;
        data_size = 0; data_addr = 0; data_wdata = 0;
        bus_addr_ok = 0; bus_data_ok = 0; bus_rdata = 0;
    endtask

    task automatic model_reset();
        q.delete();
        pend = -1; exp_err = 0; inst_busy = 0; data_busy = 0;
    endtask

    initial begin
        resetn = 1'b0;
        idle_inputs();
        #3;
        check_eq("rst_bus_req", bus_req, 1'b0);
        check_eq("rst_oks", {inst_addr_ok, data_addr_ok, inst_data_ok, data_data_ok}, 4'd0);
        check_eq("rst_cnt_err", {outst_cnt, err}, '0);
        @(posedge clk); #1 resetn = 1'b1;

        // Single fetch: accepted one cycle late, answered the cycle after.
        @(posedge clk); #1 inst_req = 1; inst_addr = 32'hBFC0_0000;
        @(negedge clk); eval_cycle();
        @(posedge clk); #1 bus_addr_ok = 1;
        @(negedge clk); eval_cycle();
        @(posedge clk); #1 inst_req = 0; bus_addr_ok = 0; bus_data_ok = 1; bus_rdata = 32'h3C08_0001;
        @(negedge clk); eval_cycle();
        @(posedge clk); #1 bus_data_ok = 0;
        @(negedge clk); eval_cycle();

        // Randomized traffic with light, sparse and heavy response rates.
        for (int i = 0; i < 600; i++) step(50, 60, 1'b1);
        for (int i = 0; i < 600; i++) step(10, 70, 1'b1);
        for (int i = 0; i < 600; i++) step(90, 50, 1'b1);
        check_eq("full_reached", n_full_seen > 0, 1'b1);

        // Drain: no new requests, pending ones are accepted, all responses return.
        for (int i = 0; i < 100 && (q.size() > 0 || inst_busy || data_busy); i++)
            step(100, 100, 1'b0);
        check_eq("drained", q.size() == 0 && !inst_busy && !data_busy, 1'b1);

        // Response with nothing outstanding: ignored, err becomes sticky.
        @(posedge clk); #1 idle_inputs(); bus_data_ok = 1;
        @(negedge clk); eval_cycle();
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1 bus_data_ok = 0;
            @(negedge clk); eval_cycle();
        end

        // Build up outstanding traffic, then reset asynchronously mid-cycle.
        for (int i = 0; i < 6; i++) step(0, 80, 1'b1);
        @(posedge clk); #1 idle_inputs(); resetn = 1'b0;
        #1;
        check_eq("arst_bus_req", bus_req, 1'b0);
        check_eq("arst_oks", {inst_addr_ok, data_addr_ok, inst_data_ok, data_data_ok}, 4'd0);
        check_eq("arst_cnt_err", {outst_cnt, err}, '0);
        model_reset();
        @(posedge clk); #1 resetn = 1'b1;

        // Locked inst request withdrawn before acceptance: protocol error.
        @(posedge clk); #1 inst_req = 1; inst_addr = 32'h0000_1000;
        @(negedge clk); eval_cycle();
        @(posedge clk); #1 inst_req = 0; data_req = 1; data_addr = 32'h8000_0010;
        data_wr = 1; data_wstrb = 4'b0011; data_wdata = 32'h1234;
        @(negedge clk); eval_cycle();
        @(posedge clk); #1 bus_addr_ok = 1;
        @(negedge clk); eval_cycle();
        @(posedge clk); #1 idle_inputs();
        @(negedge clk); eval_cycle();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule
